// File: rtl/eth_frame_log_pkg.sv
// Shared types and constants for the frame log packer: FSM states, header
// field layout, ctl entry layout and the payload word-count helper.
package eth_frame_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DRAIN
    } state_t;

    localparam logic [15:0] C_MAGIC_DEFAULT = 16'hF7A3;

    // Header layout (128 bits, emitted least-significant word first)
    localparam int HDR_BITS        = 128;
    localparam int HDR_TS_LSB      = 0;
    localparam int HDR_SIZE_LSB    = 64;
    localparam int HDR_MATCHED_LSB = 80;
    localparam int HDR_MAGIC_LSB   = 112;

    // Ctl entry layout: {MATCHED, SIZE[15:0], TIMESTAMP[63:0]}
    localparam int CTL_TS_LSB      = 0;
    localparam int CTL_SIZE_LSB    = 64;
    localparam int CTL_MATCHED_LSB = 80;

    // ceil(size / bytes) in 17 bits so SIZE=0xFFFF cannot overflow.
    function automatic logic [16:0] words_for_size(input logic [15:0] size,
                                                   input int unsigned bytes);
        logic [16:0] sum;
        sum = {1'b0, size} + 17'(bytes - 1);
        case (bytes)
            4:       return sum >> 2;
            16:      return sum >> 4;
            default: return sum >> 3;
        endcase
    endfunction

endpackage

// File: rtl/eth_frame_log_packer.sv
// Merges each ctl entry with its packed frame words into one AXIS log packet:
// 128-bit header, then the payload words, tlast on the final word.
module eth_frame_log_packer
    import eth_frame_log_pkg::*;
#(
    parameter int          C_NUM_SCRIPTS_CEIL = 8,
    parameter int          C_AXIS_LOG_WIDTH   = 64,
    parameter logic [15:0] C_MAGIC            = C_MAGIC_DEFAULT
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            enable,
    input  logic [C_NUM_SCRIPTS_CEIL+79:0]  s_axis_ctl_tdata,
    input  logic                            s_axis_ctl_tvalid,
    output logic                            s_axis_ctl_tready,
    input  logic [C_AXIS_LOG_WIDTH-1:0]     s_axis_frame_tdata,
    input  logic                            s_axis_frame_tvalid,
    output logic                            s_axis_frame_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]     m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [63:0]                     packet_count,
    output logic [63:0]                     drop_count
);

    localparam int          NSC    = C_NUM_SCRIPTS_CEIL;
    localparam int          W      = C_AXIS_LOG_WIDTH;
    localparam int unsigned B      = W / 8;
    localparam int          HW     = HDR_BITS / W;
    localparam logic [1:0]  K_LAST = 2'(HW - 1);

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d, k_next;
    logic [16:0]     cnt_q, cnt_d, nw_new;
    logic [127:0]    hdr_q, hdr_d, hdr_new;
    logic [W-1:0]    tdata_d;
    logic            tvalid_d, tlast_d;
    logic            ctl_rdy, frm_rdy;
    logic            ctl_hs, frame_hs, out_hs;
    logic            pkt_inc, drop_inc;

    logic [63:0]     ctl_ts;
    logic [15:0]     ctl_size;
    logic [NSC-1:0]  ctl_matched;

    assign ctl_ts      = s_axis_ctl_tdata[CTL_TS_LSB +: 64];
    assign ctl_size    = s_axis_ctl_tdata[CTL_SIZE_LSB +: 16];
    assign ctl_matched = s_axis_ctl_tdata[CTL_MATCHED_LSB +: NSC];
    assign nw_new      = words_for_size(ctl_size, B);

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can infer a latch.
    always_comb begin
        hdr_new = '0;
        hdr_new[HDR_TS_LSB +: 64]      = ctl_ts;
        hdr_new[HDR_SIZE_LSB +: 16]    = ctl_size;
        hdr_new[HDR_MATCHED_LSB +: 32] = 32'(ctl_matched);
        hdr_new[HDR_MAGIC_LSB +: 16]   = C_MAGIC;
    end

    // Readies depend only on registered state and m_axis_tready, keeping the
    // handshake terms free of loops through the next-state logic.
    always_comb begin
        ctl_rdy = 1'b0;
        frm_rdy = 1'b0;
        case (state_q)
            ST_IDLE:   ctl_rdy = ~m_axis_tvalid;
            // Pre-fetch the first payload word while the last header word leaves,
            // so header and payload go out back to back.
            ST_HEADER: frm_rdy = (k_q == K_LAST) && (cnt_q != '0) && m_axis_tready;
            ST_DATA:   frm_rdy = (cnt_q != '0) && (~m_axis_tvalid || m_axis_tready);
            ST_DRAIN:  frm_rdy = (cnt_q != '0);
            default:   ;
        endcase
    end

    assign s_axis_ctl_tready   = ctl_rdy & ~srst;
    assign s_axis_frame_tready = frm_rdy & ~srst;

    assign ctl_hs   = s_axis_ctl_tvalid & s_axis_ctl_tready;
    assign frame_hs = s_axis_frame_tvalid & s_axis_frame_tready;
    assign out_hs   = m_axis_tvalid & m_axis_tready;
    assign k_next   = k_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        tdata_d  = m_axis_tdata;
        tvalid_d = m_axis_tvalid;
        tlast_d  = m_axis_tlast;
        drop_inc = 1'b0;
        pkt_inc  = out_hs & m_axis_tlast;

        case (state_q)
            ST_IDLE: begin
                if (ctl_hs) begin
                    hdr_d = hdr_new;
                    cnt_d = nw_new;
                    k_d   = '0;
                    if (enable) begin
                        state_d  = ST_HEADER;
                        tdata_d  = hdr_new[W-1:0];
                        tvalid_d = 1'b1;
                        tlast_d  = (HW == 1) && (nw_new == '0);
                    end else begin
                        state_d  = ST_DRAIN;
                        drop_inc = 1'b1;
                    end
                end
            end

            ST_HEADER: begin
                if (out_hs) begin
                    if (k_q != K_LAST) begin
                        k_d     = k_next;
                        tdata_d = hdr_q[32'(k_next) * W +: W];
                        tlast_d = (k_next == K_LAST) && (cnt_q == '0);
                    end else if (cnt_q == '0) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        state_d  = ST_DATA;
                        tvalid_d = frame_hs;
                        tlast_d  = frame_hs && (cnt_q == 17'd1);
                        if (frame_hs) begin
                            tdata_d = s_axis_frame_tdata;
                            cnt_d   = cnt_q - 17'd1;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (out_hs) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (m_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                if (frame_hs) begin
                    tdata_d  = s_axis_frame_tdata;
                    tvalid_d = 1'b1;
                    tlast_d  = (cnt_q == 17'd1);
                    cnt_d    = cnt_q - 17'd1;
                end
            end

            ST_DRAIN: begin
                if (frame_hs) begin
                    cnt_d = cnt_q - 17'd1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            k_q           <= '0;
            cnt_q         <= '0;
            hdr_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            packet_count  <= '0;
            drop_count    <= '0;
        end else begin
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            hdr_q         <= hdr_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            if (pkt_inc) begin
                packet_count <= packet_count + 64'd1;
            end
            if (drop_inc) begin
                drop_count <= drop_count + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_log_packer.sv
// Directed and randomized checks of the frame log packer at W=64, plus a
// short W=32 header/payload sequence on a second instance.
module tb_eth_frame_log_packer;

    logic        clk = 1'b0;
    logic        srst;
    logic        enable;
    logic [87:0] s_axis_ctl_tdata;
    logic        s_axis_ctl_tvalid;
    logic        s_axis_ctl_tready;
    logic [63:0] s_axis_frame_tdata;
    logic        s_axis_frame_tvalid;
    logic        s_axis_frame_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] packet_count;
    logic [63:0] drop_count;

    logic        c32_enable;
    logic [87:0] c32_ctl_tdata;
    logic        c32_ctl_tvalid, c32_ctl_tready;
    logic [31:0] c32_frame_tdata;
    logic        c32_frame_tvalid, c32_frame_tready;
    logic [31:0] c32_tdata;
    logic        c32_tlast, c32_tvalid, c32_tready;
    logic [63:0] c32_pkt, c32_drop;

    always #5 clk = ~clk;

    eth_frame_log_packer #(.C_NUM_SCRIPTS_CEIL(8), .C_AXIS_LOG_WIDTH(64)) dut (
        .clk(clk), .srst(srst), .enable(enable),
        .s_axis_ctl_tdata(s_axis_ctl_tdata), .s_axis_ctl_tvalid(s_axis_ctl_tvalid),
        .s_axis_ctl_tready(s_axis_ctl_tready),
        .s_axis_frame_tdata(s_axis_frame_tdata), .s_axis_frame_tvalid(s_axis_frame_tvalid),
        .s_axis_frame_tready(s_axis_frame_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .packet_count(packet_count), .drop_count(drop_count)
    );

    eth_frame_log_packer #(.C_NUM_SCRIPTS_CEIL(8), .C_AXIS_LOG_WIDTH(32)) dut32 (
        .clk(clk), .srst(srst), .enable(c32_enable),
        .s_axis_ctl_tdata(c32_ctl_tdata), .s_axis_ctl_tvalid(c32_ctl_tvalid),
        .s_axis_ctl_tready(c32_ctl_tready),
        .s_axis_frame_tdata(c32_frame_tdata), .s_axis_frame_tvalid(c32_frame_tvalid),
        .s_axis_frame_tready(c32_frame_tready),
        .m_axis_tdata(c32_tdata), .m_axis_tlast(c32_tlast),
        .m_axis_tvalid(c32_tvalid), .m_axis_tready(c32_tready),
        .packet_count(c32_pkt), .drop_count(c32_drop)
    );

    typedef struct {
        bit          en;
        logic [7:0]  matched;
        logic [15:0] size;
        logic [63:0] ts;
        int          nw;
        logic [63:0] hdr1;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        bit          last;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [87:0] data;
        bit          en;
    } ctl_ent_t;

    ctl_ent_t    ctl_q[$];
    logic [63:0] frm_q[$];
    obs_t        out_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ready_pct, gap_pct;
    int frame_pops   = 0;
    int valid_cycles = 0;
    int stall_err    = 0;
    logic [63:0] exp_pkts  = 0;
    logic [63:0] exp_drops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus model for the W=64 instance: drives at negedge, samples handshakes 1ns later.
    initial begin : bfm
        bit p_ctl, p_frm, p_out, p_stall;
        obs_t cap;
        logic [63:0] pd;
        bit pl;
        p_ctl = 0; p_frm = 0; p_out = 0; p_stall = 0; pd = '0; pl = 0;
        forever begin
            @(negedge clk);
            if (srst) begin
                s_axis_ctl_tvalid   = 1'b0;
                s_axis_frame_tvalid = 1'b0;
                m_axis_tready       = 1'b0;
                p_ctl = 0; p_frm = 0; p_out = 0; p_stall = 0;
            end else begin
                if (p_ctl) begin
                    void'(ctl_q.pop_front());
                    s_axis_ctl_tvalid = 1'b0;
                end
                if (p_frm) begin
                    void'(frm_q.pop_front());
                    s_axis_frame_tvalid = 1'b0;
                    frame_pops++;
                end
                if (p_out) out_q.push_back(cap);
                if (!s_axis_ctl_tvalid && ctl_q.size() > 0) begin
                    s_axis_ctl_tvalid = 1'b1;
                    s_axis_ctl_tdata  = ctl_q[0].data;
                    enable            = ctl_q[0].en;
                end
                if (!s_axis_frame_tvalid && frm_q.size() > 0 &&
                    $urandom_range(99) >= gap_pct) begin
                    s_axis_frame_tvalid = 1'b1;
                    s_axis_frame_tdata  = frm_q[0];
                end
                m_axis_tready = ($urandom_range(99) < ready_pct);
                #1;
                if (p_stall && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
                    stall_err++;
                p_stall = m_axis_tvalid && !m_axis_tready;
                pd      = m_axis_tdata;
                pl      = m_axis_tlast;
                if (m_axis_tvalid) valid_cycles++;
                p_ctl = s_axis_ctl_tvalid && s_axis_ctl_tready;
                p_frm = s_axis_frame_tvalid && s_axis_frame_tready;
                p_out = m_axis_tvalid && m_axis_tready;
                cap   = '{data: m_axis_tdata, last: m_axis_tlast, cyc: cyc};
            end
        end
    end

    task automatic wait_idle(input int n, input int budget, input string tag);
        int t = 0;
        while ((out_q.size() < n || ctl_q.size() != 0 || frm_q.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done"}, 64'(t < budget), 64'd1);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int base_pops  = frame_pops;
        int base_valid = valid_cycles;
        int n, bad_pl, bad_last;
        out_q.delete();
        ctl_q.push_back('{data: {v.matched, v.size, v.ts}, en: v.en});
        for (int j = 0; j < v.nw; j++) frm_q.push_back({32'hD000_0000 | 32'(idx), 32'(j)});
        n = v.en ? 2 + v.nw : 0;
        wait_idle(n, 12000, $sformatf("v%0d", idx));
        if (v.en) exp_pkts++;
        else      exp_drops++;
        check($sformatf("v%0d_frame_pops", idx), 64'(frame_pops - base_pops), 64'(v.nw));
        check($sformatf("v%0d_packet_count", idx), packet_count, exp_pkts);
        check($sformatf("v%0d_drop_count", idx), drop_count, exp_drops);
        if (v.en) begin
            check($sformatf("v%0d_words", idx), 64'(out_q.size()), 64'(n));
            if (out_q.size() == n) begin
                bad_pl = 0;
                bad_last = 0;
                for (int j = 0; j < n; j++) begin
                    if (out_q[j].last != (j == n - 1)) bad_last++;
                    if (j >= 2 && out_q[j].data !== {32'hD000_0000 | 32'(idx), 32'(j - 2)}) bad_pl++;
                end
                check($sformatf("v%0d_hdr0", idx), out_q[0].data, v.ts);
                check($sformatf("v%0d_hdr1", idx), out_q[1].data, v.hdr1);
                check($sformatf("v%0d_payload_errs", idx), 64'(bad_pl), 64'd0);
                check($sformatf("v%0d_tlast_errs", idx), 64'(bad_last), 64'd0);
                check($sformatf("v%0d_span", idx), 64'(out_q[n-1].cyc - out_q[0].cyc + 1), 64'(n));
            end
        end else begin
            check($sformatf("v%0d_drain_valid", idx), 64'(valid_cycles - base_valid), 64'd0);
        end
    endtask

    initial begin : main
        vec_t        vecs[7];
        obs_t        exp_q[$];
        logic [31:0] f32[2];
        logic [31:0] e32[6];
        logic [31:0] o32[$];
        bit          l32[$];
        logic [5:0]  lastv;
        int          fi, t, mism, total, bad_last;
        bit          cth, fth, oth, cl;
        logic [31:0] cd;

        vecs[0] = '{1'b1, 8'h05, 16'd12,     64'h1122334455667788, 2,    64'hF7A3_0000_0005_000C};
        vecs[1] = '{1'b1, 8'h00, 16'd0,      64'h0123456789ABCDEF, 0,    64'hF7A3_0000_0000_0000};
        vecs[2] = '{1'b0, 8'h33, 16'd20,     64'h5555AAAA5555AAAA, 3,    64'h0};
        vecs[3] = '{1'b1, 8'h5A, 16'd9,      64'h0F0E0D0C0B0A0908, 2,    64'hF7A3_0000_005A_0009};
        vecs[4] = '{1'b1, 8'hFF, 16'd64,     64'hFEDCBA9876543210, 8,    64'hF7A3_0000_00FF_0040};
        vecs[5] = '{1'b1, 8'h80, 16'd1,      64'h00000000DEADBEEF, 1,    64'hF7A3_0000_0080_0001};
        vecs[6] = '{1'b1, 8'h01, 16'hFFFF,   64'h7777666655554444, 8192, 64'hF7A3_0000_0001_FFFF};

        srst = 1'b1; enable = 1'b0; s_axis_ctl_tdata = '0; s_axis_ctl_tvalid = 1'b0;
        s_axis_frame_tdata = '0; s_axis_frame_tvalid = 1'b0; m_axis_tready = 1'b0;
        c32_enable = 1'b1; c32_ctl_tdata = '0; c32_ctl_tvalid = 1'b0;
        c32_frame_tdata = '0; c32_frame_tvalid = 1'b0; c32_tready = 1'b0;
        ready_pct = 100; gap_pct = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_ctl_tready", 64'(s_axis_ctl_tready), 64'd0);
        check("rst_frame_tready", 64'(s_axis_frame_tready), 64'd0);
        check("rst_packet_count", packet_count, 64'd0);
        check("rst_drop_count", drop_count, 64'd0);
        @(negedge clk);
        #2 srst = 1'b0;

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

        // Randomized traffic under output backpressure and frame-side gaps.
        ready_pct = 30; gap_pct = 20;
        out_q.delete();
        for (int p = 0; p < 200; p++) begin
            logic [15:0] sz;
            logic [7:0]  m;
            logic [63:0] ts, w;
            int          nw;
            sz = 16'($urandom_range(1518, 1));
            m  = 8'($urandom);
            ts = {$urandom, $urandom};
            nw = (int'(sz) + 7) / 8;
            ctl_q.push_back('{data: {m, sz, ts}, en: 1'b1});
            exp_q.push_back('{data: ts, last: 1'b0, cyc: 0});
            exp_q.push_back('{data: {16'hF7A3, 24'h0, m, sz}, last: 1'b0, cyc: 0});
            for (int j = 0; j < nw; j++) begin
                w = {$urandom, $urandom};
                frm_q.push_back(w);
                exp_q.push_back('{data: w, last: (j == nw - 1), cyc: 0});
            end
        end
        total = exp_q.size();
        wait_idle(total, 80000, "rand");
        exp_pkts += 200;
        check("rand_words", 64'(out_q.size()), 64'(total));
        mism = 0;
        bad_last = 0;
        for (int j = 0; j < total && j < out_q.size(); j++) begin
            if (out_q[j].data !== exp_q[j].data) mism++;
            if (out_q[j].last != exp_q[j].last) bad_last++;
        end
        check("rand_data_errs", 64'(mism), 64'd0);
        check("rand_tlast_errs", 64'(bad_last), 64'd0);
        check("rand_packet_count", packet_count, exp_pkts);
        check("rand_stall_errs", 64'(stall_err), 64'd0);

        // Synchronous reset in the middle of a 10-word payload.
        ready_pct = 50; gap_pct = 0;
        out_q.delete();
        ctl_q.push_back('{data: {8'h0A, 16'd80, 64'hABCD0000ABCD0000}, en: 1'b1});
        for (int j = 0; j < 10; j++) frm_q.push_back(64'(j));
        t = 0;
        while (out_q.size() < 4 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("srst_reached_data", 64'(out_q.size() >= 4), 64'd1);
        @(posedge clk);
        #2 srst = 1'b1;
        ctl_q.delete();
        frm_q.delete();
        @(posedge clk);
        #2;
        check("srst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("srst_tlast", 64'(m_axis_tlast), 64'd0);
        check("srst_ctl_tready", 64'(s_axis_ctl_tready), 64'd0);
        check("srst_frame_tready", 64'(s_axis_frame_tready), 64'd0);
        check("srst_packet_count", packet_count, 64'd0);
        check("srst_drop_count", drop_count, 64'd0);
        bad_last = 0;
        foreach (out_q[j]) if (out_q[j].last) bad_last++;
        check("srst_no_tlast", 64'(bad_last), 64'd0);
        @(negedge clk);
        #2 srst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
        ready_pct = 100;
        apply_vec(vecs[0], 10);

        // W=32: four header words, then two payload words.
        f32[0] = 32'hCAFE0001; f32[1] = 32'hCAFE0002;
        e32[0] = 32'h11223344; e32[1] = 32'hAABBCCDD; e32[2] = 32'h00050005;
        e32[3] = 32'hF7A30000; e32[4] = 32'hCAFE0001; e32[5] = 32'hCAFE0002;
        fi = 0;
        @(negedge clk);
        c32_ctl_tdata    = {8'h05, 16'd5, 64'hAABBCCDD11223344};
        c32_ctl_tvalid   = 1'b1;
        c32_frame_tdata  = f32[0];
        c32_frame_tvalid = 1'b1;
        c32_tready       = 1'b1;
        for (int k = 0; k < 60 && o32.size() < 6; k++) begin
            #1;
            cth = c32_ctl_tvalid && c32_ctl_tready;
            fth = c32_frame_tvalid && c32_frame_tready;
            oth = c32_tvalid && c32_tready;
            cd  = c32_tdata;
            cl  = c32_tlast;
            @(negedge clk);
            if (cth) c32_ctl_tvalid = 1'b0;
            if (fth) begin
                fi++;
                if (fi < 2) c32_frame_tdata = f32[fi];
                else        c32_frame_tvalid = 1'b0;
            end
            if (oth) begin
                o32.push_back(cd);
                l32.push_back(cl);
            end
        end
        repeat (3) @(negedge clk);
        check("w32_words", 64'(o32.size()), 64'd6);
        lastv = '0;
        for (int k = 0; k < o32.size() && k < 6; k++) begin
            check($sformatf("w32_word%0d", k), 64'(o32[k]), 64'(e32[k]));
            lastv[k] = l32[k];
        end
        check("w32_tlast_pattern", 64'(lastv), 64'(6'b100000));
        check("w32_packet_count", c32_pkt, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
